// File: rtl/bank_wbuf_responder.sv
// Write buffer for a cache bank: channel-side fills park data per {channel, id}
// entry, and bank SRAM reads pull it out through a one-deep return register.
module bank_wbuf_responder #(
  parameter int DW       = 128,
  parameter int WB_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wb_fill_valid_i,
  output logic                            wb_fill_ready_o,
  input  logic [1:0]                      wb_fill_channel_id_i,
  input  logic [7:0]                      wb_fill_wbuffer_id_i,
  input  logic [DW-1:0]                   wb_fill_data_i,
  input  logic                            rc_wbuf_req_valid_i,
  output logic                            rc_wbuf_req_ready_o,
  input  logic [1:0]                      rc_wbuf_req_channel_id_i,
  input  logic [7:0]                      rc_wbuf_req_wbuffer_id_i,
  output logic                            rc_wbuf_rtn_valid_o,
  input  logic                            rc_wbuf_rtn_ready_i,
  output logic [DW-1:0]                   rc_wbuf_rtn_data_o,
  output logic [4*WB_DEPTH-1:0]           wb_entry_valid_o,
  output logic [$clog2(4*WB_DEPTH):0]     wb_occupancy_o
);

  // Handshakes: a transfer happens on a clk_i edge where valid and ready are
  // both 1; ready never depends on valid, and the return side holds data
  // stable while rtn_valid=1 and rtn_ready=0.

  localparam int IDX_W = $clog2(WB_DEPTH);
  localparam int NUM   = 4 * WB_DEPTH;
  localparam int EW    = IDX_W + 2;
  localparam int OCC_W = $clog2(NUM) + 1;

  logic [NUM-1:0]   entry_valid_q;
  logic [DW-1:0]    entry_data_q [NUM];
  logic [EW-1:0]    fill_idx;
  logic [EW-1:0]    req_idx;
  logic             fill_fire;
  logic             req_fire;
  logic             rtn_valid_q;
  logic [DW-1:0]    rtn_data_q;
  logic [OCC_W-1:0] occ_q;
  logic             unused_id_bits;

  assign fill_idx = {wb_fill_channel_id_i, wb_fill_wbuffer_id_i[IDX_W-1:0]};
  assign req_idx  = {rc_wbuf_req_channel_id_i, rc_wbuf_req_wbuffer_id_i[IDX_W-1:0]};
  assign unused_id_bits = ^{wb_fill_wbuffer_id_i[7:IDX_W], rc_wbuf_req_wbuffer_id_i[7:IDX_W]};

  // Readies are forced low under reset so nothing can be mistaken for a transfer.
  assign wb_fill_ready_o     = ~rst_i & ~entry_valid_q[fill_idx];
  assign rc_wbuf_req_ready_o = ~rst_i & entry_valid_q[req_idx]
                               & (~rtn_valid_q | rc_wbuf_rtn_ready_i);

  assign fill_fire = wb_fill_valid_i & wb_fill_ready_o;
  assign req_fire  = rc_wbuf_req_valid_i & rc_wbuf_req_ready_o;

  // A fill and a read can never hit the same entry in one cycle: one needs it
  // empty, the other needs it occupied.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_valid_q <= '0;
    end else begin
      if (req_fire)  entry_valid_q[req_idx]  <= 1'b0;
      if (fill_fire) entry_valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_fire) entry_data_q[fill_idx] <= wb_fill_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      case ({fill_fire, req_fire})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rtn_valid_q <= 1'b0;
      rtn_data_q  <= '0;
    end else if (req_fire) begin
      rtn_valid_q <= 1'b1;
      rtn_data_q  <= entry_data_q[req_idx];
    end else if (rc_wbuf_rtn_ready_i) begin
      rtn_valid_q <= 1'b0;
    end
  end

  assign rc_wbuf_rtn_valid_o = rtn_valid_q;
  assign rc_wbuf_rtn_data_o  = rtn_data_q;
  assign wb_entry_valid_o    = entry_valid_q;
  assign wb_occupancy_o      = occ_q;

endmodule

// File: tb/tb_bank_wbuf_responder.sv
// Directed bench for bank_wbuf_responder with a queue-based reference model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_bank_wbuf_responder;
  localparam int DW       = 128;
  localparam int WB_DEPTH = 4;
  localparam int NUM      = 4 * WB_DEPTH;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           fill_valid;
  logic           fill_ready;
  logic [1:0]     fill_ch;
  logic [7:0]     fill_id;
  logic [DW-1:0]  fill_data;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_ch;
  logic [7:0]     req_id;
  logic           rtn_valid;
  logic           rtn_ready;
  logic [DW-1:0]  rtn_data;
  logic [NUM-1:0] entry_valid;
  logic [4:0]     occupancy;

  always #5 clk = ~clk;

  bank_wbuf_responder #(.DW(DW), .WB_DEPTH(WB_DEPTH)) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .wb_fill_valid_i          (fill_valid),
    .wb_fill_ready_o          (fill_ready),
    .wb_fill_channel_id_i     (fill_ch),
    .wb_fill_wbuffer_id_i     (fill_id),
    .wb_fill_data_i           (fill_data),
    .rc_wbuf_req_valid_i      (req_valid),
    .rc_wbuf_req_ready_o      (req_ready),
    .rc_wbuf_req_channel_id_i (req_ch),
    .rc_wbuf_req_wbuffer_id_i (req_id),
    .rc_wbuf_rtn_valid_o      (rtn_valid),
    .rc_wbuf_rtn_ready_i      (rtn_ready),
    .rc_wbuf_rtn_data_o       (rtn_data),
    .wb_entry_valid_o         (entry_valid),
    .wb_occupancy_o           (occupancy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-entry occupancy and contents, plus a queue of
  // returns the consumer has not yet taken.
  bit            mv [NUM];
  logic [DW-1:0] md [NUM];
  logic [DW-1:0] exp_q [$];

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int eidx(logic [1:0] ch, logic [7:0] id);
    return int'(ch) * WB_DEPTH + int'(id) % WB_DEPTH;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int fi;
    int ri;
    bit ff;
    bit rf;
    if (rst) begin
      foreach (mv[i]) mv[i] = 1'b0;
      exp_q.delete();
    end else begin
      fi = eidx(fill_ch, fill_id);
      ri = eidx(req_ch, req_id);
      ff = fill_valid && !mv[fi];
      rf = req_valid && mv[ri] && (exp_q.size() == 0 || rtn_ready);
      if (rtn_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (rf) begin
        exp_q.push_back(md[ri]);
        mv[ri] = 1'b0;
      end
      if (ff) begin
        md[fi] = fill_data;
        mv[fi] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [NUM-1:0] e_ev;
    int             e_occ;
    e_occ = 0;
    for (int i = 0; i < NUM; i++) begin
      e_ev[i] = mv[i];
      e_occ += mv[i] ? 1 : 0;
    end
    if (rst) begin
      chk("cyc_rst_entry_valid", entry_valid, '0);
      chk("cyc_rst_occupancy", occupancy, '0);
      chk("cyc_rst_rtn_valid", rtn_valid, '0);
      chk("cyc_rst_rtn_data", rtn_data, '0);
    end else begin
      chk("cyc_fill_ready", fill_ready, !mv[eidx(fill_ch, fill_id)]);
      chk("cyc_req_ready", req_ready,
          mv[eidx(req_ch, req_id)] && (exp_q.size() == 0 || rtn_ready));
      chk("cyc_rtn_valid", rtn_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("cyc_rtn_data", rtn_data, exp_q[0]);
      chk("cyc_entry_valid", entry_valid, e_ev);
      chk("cyc_occupancy", occupancy, e_occ);
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_fill(bit v, logic [1:0] ch, logic [7:0] id, logic [DW-1:0] d);
    fill_valid = v;
    fill_ch    = ch;
    fill_id    = id;
    fill_data  = d;
  endtask

  task automatic set_req(bit v, logic [1:0] ch, logic [7:0] id);
    req_valid = v;
    req_ch    = ch;
    req_id    = id;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [DW-1:0] d_a5;
    logic [DW-1:0] d34;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] dn;
    logic [DW-1:0] d37;
    logic [DW-1:0] d28;
    d_a5 = {16{8'hA5}};
    d34  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    d1   = {4{32'h1111_0001}};
    d2   = {4{32'h2222_0002}};
    dn   = {4{32'hBEEF_0033}};
    d37  = {4{32'h3737_3737}};
    d28  = {4{32'h2828_2828}};
    set_fill(1'b0, 2'd0, 8'd0, '0);
    set_req(1'b0, 2'd0, 8'd0);
    rtn_ready = 1'b1;

    // Reset values
    #2;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_entry_valid", entry_valid, 0);
    chk("rst_rtn_valid", rtn_valid, 0);
    chk("rst_rtn_data", rtn_data, 0);
    cyc(2);
    rst = 1'b0;

    // Basic fill then read of ch1/id2 (entry 6)
    set_fill(1'b1, 2'd1, 8'd2, d_a5);
    #1 chk("t1_fill_ready", fill_ready, 1);
    cyc();
    set_fill(1'b0, 2'd0, 8'd0, '0);
    #1 chk("t1_ev6_set", entry_valid[6], 1);
    chk("t1_occ_1", occupancy, 1);
    set_req(1'b1, 2'd1, 8'd2);
    #1 chk("t1_req_ready", req_ready, 1);
    cyc();
    set_req(1'b0, 2'd0, 8'd0);
    #1 chk("t1_rtn_valid", rtn_valid, 1);
    chk("t1_rtn_data", rtn_data, d_a5);
    chk("t1_ev6_clr", entry_valid[6], 0);
    chk("t1_occ_0", occupancy, 0);
    cyc();
    chk("t1_rtn_drop", rtn_valid, 0);

    // Request to empty entry stalls, then a fill arrives in the same cycle
    set_req(1'b1, 2'd0, 8'd0);
    repeat (3) begin
      #1 chk("t2_req_stall", req_ready, 0);
      cyc();
    end
    set_fill(1'b1, 2'd0, 8'd0, d34);
    #1 chk("t2_same_cyc_req_ready", req_ready, 0);
    chk("t2_same_cyc_fill_ready", fill_ready, 1);
    cyc();
    set_fill(1'b0, 2'd0, 8'd0, '0);
    #1 chk("t2_req_ready_after_fill", req_ready, 1);
    chk("t2_no_rtn_yet", rtn_valid, 0);
    cyc();
    set_req(1'b0, 2'd0, 8'd0);
    #1 chk("t2_rtn_data", rtn_data, d34);
    chk("t2_rtn_valid", rtn_valid, 1);
    cyc();

    // Backpressure on the return side, then back-to-back returns
    rtn_ready = 1'b0;
    set_fill(1'b1, 2'd2, 8'd1, d1);
    cyc();
    set_fill(1'b1, 2'd2, 8'd3, d2);
    cyc();
    set_fill(1'b0, 2'd0, 8'd0, '0);
    set_req(1'b1, 2'd2, 8'd1);
    #1 chk("t3_occ_2", occupancy, 2);
    chk("t3_req1_ready", req_ready, 1);
    cyc();
    set_req(1'b1, 2'd2, 8'd3);
    #1 chk("t3_req2_blocked", req_ready, 0);
    chk("t3_rtn1_data", rtn_data, d1);
    cyc(2);
    #1 chk("t3_rtn1_held", rtn_data, d1);
    chk("t3_rtn1_valid_held", rtn_valid, 1);
    chk("t3_req2_still_blocked", req_ready, 0);
    rtn_ready = 1'b1;
    #1 chk("t3_req2_ready", req_ready, 1);
    cyc();
    set_req(1'b0, 2'd0, 8'd0);
    #1 chk("t3_b2b_valid", rtn_valid, 1);
    chk("t3_rtn2_data", rtn_data, d2);
    cyc();
    chk("t3_rtn_drop", rtn_valid, 0);
    chk("t3_occ_0", occupancy, 0);

    // Fill every entry; upper id bits are junk and must be ignored
    for (int i = 0; i < NUM; i++) begin
      set_fill(1'b1, 2'(i / 4), 8'((i % 4) + 4 * i), {4{32'hC0DE_0000 + 32'(i)}});
      cyc();
    end
    set_fill(1'b0, 2'd0, 8'd0, '0);
    #1 chk("t4_occ_full", occupancy, 16);
    chk("t4_ev_full", entry_valid, 16'hFFFF);
    for (int i = 0; i < NUM; i++) begin
      set_fill(1'b0, 2'(i / 4), 8'(i % 4), '0);
      #1 chk("t4_fill_ready_full", fill_ready, 0);
    end
    set_fill(1'b1, 2'd3, 8'd3, dn);
    cyc(2);
    chk("t4_refill_blocked", fill_ready, 0);
    set_req(1'b1, 2'd3, 8'd3);
    #1 chk("t4_req_ready", req_ready, 1);
    cyc();
    set_req(1'b0, 2'd0, 8'd0);
    #1 chk("t4_refill_open", fill_ready, 1);
    chk("t4_old_data", rtn_data, {4{32'hC0DE_000F}});
    chk("t4_occ_15", occupancy, 15);
    cyc();
    set_fill(1'b0, 2'd0, 8'd0, '0);
    #1 chk("t4_ev15_refilled", entry_valid[15], 1);
    chk("t4_occ_16", occupancy, 16);

    // Same-cycle fill and request to one empty entry (entry 1)
    set_req(1'b1, 2'd0, 8'd1);
    cyc();
    set_req(1'b0, 2'd0, 8'd0);
    #1 chk("t5_old_data", rtn_data, {4{32'hC0DE_0001}});
    set_fill(1'b1, 2'd0, 8'd1, d37);
    set_req(1'b1, 2'd0, 8'd1);
    #1 chk("t5_req_not_ready", req_ready, 0);
    chk("t5_fill_ready", fill_ready, 1);
    cyc();
    set_fill(1'b0, 2'd0, 8'd0, '0);
    #1 chk("t5_req_ready_next", req_ready, 1);
    chk("t5_occ_16", occupancy, 16);
    cyc();
    set_req(1'b0, 2'd0, 8'd0);
    #1 chk("t5_new_data", rtn_data, d37);
    chk("t5_occ_15", occupancy, 15);

    // Fill and request to different entries in the same cycle
    set_fill(1'b1, 2'd0, 8'd1, d28);
    set_req(1'b1, 2'd0, 8'd2);
    #1 chk("t6_fill_ready", fill_ready, 1);
    chk("t6_req_ready", req_ready, 1);
    cyc();
    set_fill(1'b0, 2'd0, 8'd0, '0);
    set_req(1'b0, 2'd0, 8'd0);
    #1 chk("t6_rtn_data", rtn_data, {4{32'hC0DE_0002}});
    chk("t6_ev1", entry_valid[1], 1);
    chk("t6_ev2", entry_valid[2], 0);
    chk("t6_occ_15", occupancy, 15);

    // Reset mid-transfer with five entries held and a return pending
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_fill(1'b1, 2'(i / 4), 8'(i % 4), {4{32'h5000_0000 + 32'(i)}});
      cyc();
    end
    set_fill(1'b0, 2'd0, 8'd0, '0);
    rtn_ready = 1'b0;
    set_req(1'b1, 2'd0, 8'd0);
    cyc();
    set_req(1'b0, 2'd0, 8'd0);
    #1 chk("t7_pre_rtn_valid", rtn_valid, 1);
    chk("t7_pre_occ_5", occupancy, 5);
    #1 rst = 1'b1;
    #1 chk("t7_rst_rtn_valid", rtn_valid, 0);
    chk("t7_rst_occ", occupancy, 0);
    chk("t7_rst_ev", entry_valid, 0);
    chk("t7_rst_fill_ready", fill_ready, 0);
    set_fill(1'b1, 2'd3, 8'd3, dn);
    set_req(1'b1, 2'd0, 8'd1);
    cyc(3);
    chk("t7_rst_hold_occ", occupancy, 0);
    set_fill(1'b0, 2'd0, 8'd0, '0);
    set_req(1'b0, 2'd0, 8'd0);
    rst = 1'b0;
    #1 chk("t7_rel_occ", occupancy, 0);
    chk("t7_rel_ev", entry_valid, 0);
    chk("t7_rel_rtn_valid", rtn_valid, 0);
    cyc(2);
    rtn_ready = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
